scoreboard_regfile: RTL and testbench

Parametrised integer register file with a per-register pending-write scoreboard. It sits between instruction decode and execute. Sources are read at issue and destinations are reserved, so issue is held off (read-after-write) until every source is free or can be bypassed from the write-back bus. Compared with the single-issue predecessor, it adds:
- proper reset
- generic width and depth
- write-back forwarding
- counter saturation back-pressure
- x0 hard-wiring
- an error flag for unmatched write-backs

---
 rtl/scoreboard_regfile.sv | 102 ++++++++++
 tb/tb_scoreboard_regfile.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - integer register file with per-register pending-write scoreboard
// Holds issue until sources are free or bypassable and the destination counter has room.
module scoreboard_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int IDX_W  = $clog2(NREG),
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             iss_valid_i,
  input  logic             iss_rs1_en_i,
  input  logic [IDX_W-1:0] iss_rs1_i,
  input  logic             iss_rs2_en_i,
  input  logic [IDX_W-1:0] iss_rs2_i,
  input  logic             iss_rd_en_i,
  input  logic [IDX_W-1:0] iss_rd_i,
  output logic             iss_ready_o,
  output logic             stall_o,
  input  logic             wb_valid_i,
  input  logic [IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             op_valid_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic             wb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_regs [NREG];
  logic [CNT_W-1:0] r_cnt  [NREG];

  logic             w_rs1_fwd, w_rs2_fwd;
  logic             w_rs1_rdy, w_rs2_rdy, w_rd_rdy;
  logic             w_accept;
  logic [XLEN-1:0]  w_rs1_val, w_rs2_val;
  logic [NREG-1:0]  w_inc, w_dec;

  // Forwarding only resolves the hazard when this write-back is the last one outstanding.
  assign w_rs1_fwd = BYPASS && wb_valid_i && (wb_rd_i == iss_rs1_i) &&
                     (iss_rs1_i != '0) && (r_cnt[iss_rs1_i] == CNT_ONE);
  assign w_rs2_fwd = BYPASS && wb_valid_i && (wb_rd_i == iss_rs2_i) &&
                     (iss_rs2_i != '0) && (r_cnt[iss_rs2_i] == CNT_ONE);

  assign w_rs1_rdy = !iss_rs1_en_i || (r_cnt[iss_rs1_i] == '0) || w_rs1_fwd;
  assign w_rs2_rdy = !iss_rs2_en_i || (r_cnt[iss_rs2_i] == '0) || w_rs2_fwd;
  assign w_rd_rdy  = !iss_rd_en_i || (iss_rd_i == '0) || (r_cnt[iss_rd_i] != CNT_MAX) ||
                     (wb_valid_i && (wb_rd_i == iss_rd_i));

  assign iss_ready_o = w_rs1_rdy && w_rs2_rdy && w_rd_rdy;
  assign stall_o     = iss_valid_i && !iss_ready_o;
  assign w_accept    = iss_valid_i && iss_ready_o;

  assign w_rs1_val = !iss_rs1_en_i ? '0 : (w_rs1_fwd ? wb_data_i : r_regs[iss_rs1_i]);
  assign w_rs2_val = !iss_rs2_en_i ? '0 : (w_rs2_fwd ? wb_data_i : r_regs[iss_rs2_i]);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NREG; i++) begin
      w_inc[i] = w_accept && iss_rd_en_i && (iss_rd_i == IDX_W'(i));
      w_dec[i] = wb_valid_i && (wb_rd_i == IDX_W'(i)) && (r_cnt[i] != '0);
    end
  end

  // Register 0 is never written and its counter never moves, so it reads 0 and is always free.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      if (wb_valid_i && (wb_rd_i != '0)) begin
        r_regs[wb_rd_i] <= wb_data_i;
      end
      for (int i = 1; i < NREG; i++) begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_valid_o <= 1'b0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      wb_err_o   <= 1'b0;
    end else begin
      op_valid_o <= w_accept;
      if (w_accept) begin
        rs1_data_o <= w_rs1_val;
        rs2_data_o <= w_rs2_val;
      end
      wb_err_o <= wb_valid_i && (wb_rd_i != '0) && (r_cnt[wb_rd_i] == '0);
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed self-checking bench for scoreboard_regfile
module tb_scoreboard_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        iss_valid_i, iss_rs1_en_i, iss_rs2_en_i, iss_rd_en_i;
  logic [4:0]  iss_rs1_i, iss_rs2_i, iss_rd_i;
  logic        iss_ready_o, stall_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        op_valid_o, wb_err_o;
  logic [31:0] rs1_data_o, rs2_data_o;

  int n_checks = 0;
  int n_errors = 0;

  scoreboard_regfile dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .iss_valid_i  (iss_valid_i),
    .iss_rs1_en_i (iss_rs1_en_i),
    .iss_rs1_i    (iss_rs1_i),
    .iss_rs2_en_i (iss_rs2_en_i),
    .iss_rs2_i    (iss_rs2_i),
    .iss_rd_en_i  (iss_rd_en_i),
    .iss_rd_i     (iss_rd_i),
    .iss_ready_o  (iss_ready_o),
    .stall_o      (stall_o),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .op_valid_o   (op_valid_o),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
    .wb_err_o     (wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic r1en, input logic [4:0] r1,
                       input logic r2en, input logic [4:0] r2,
                       input logic rden, input logic [4:0] rd);
    iss_valid_i = v;  iss_rs1_en_i = r1en; iss_rs1_i = r1;
    iss_rs2_en_i = r2en; iss_rs2_i = r2;
    iss_rd_en_i = rden; iss_rd_i = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid_i = v; wb_rd_i = rd; wb_data_i = d;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    #2 rst_i = 1'b0;
    step();
    step();
    chk("rst_op_valid", 32'(op_valid_o), 32'd0);
    chk("rst_rs1", rs1_data_o, 32'd0);
    chk("rst_rs2", rs2_data_o, 32'd0);
    chk("rst_wb_err", 32'(wb_err_o), 32'd0);
    rst_i = 1'b1;
    step();

    // free sources after reset
    issue(1, 1, 5, 1, 6, 0, 0);
    #1 chk("t1_ready", 32'(iss_ready_o), 32'd1);
    step();
    chk("t1_op_valid", 32'(op_valid_o), 32'd1);
    chk("t1_rs1", rs1_data_o, 32'd0);
    chk("t1_rs2", rs2_data_o, 32'd0);
    chk("t1_wb_err", 32'(wb_err_o), 32'd0);

    // RAW hazard on x3 resolved by bypass
    issue(1, 0, 0, 0, 0, 1, 3);
    #1 chk("t2_rd3_ready", 32'(iss_ready_o), 32'd1);
    step();
    issue(1, 1, 3, 0, 0, 0, 0);
    #1 chk("t2_raw_ready", 32'(iss_ready_o), 32'd0);
    chk("t2_raw_stall", 32'(stall_o), 32'd1);
    step();
    chk("t2_stall_op_valid", 32'(op_valid_o), 32'd0);
    wb(1, 3, 32'hDEADBEEF);
    #1 chk("t2_fwd_ready", 32'(iss_ready_o), 32'd1);
    step();
    chk("t2_fwd_op_valid", 32'(op_valid_o), 32'd1);
    chk("t2_fwd_rs1", rs1_data_o, 32'hDEADBEEF);
    chk("t2_fwd_wb_err", 32'(wb_err_o), 32'd0);
    wb(0, 0, 0);

    // counter saturation on x7
    for (int k = 0; k < 3; k++) begin
      issue(1, 0, 0, 0, 0, 1, 7);
      #1 chk($sformatf("t3_rsv%0d_ready", k), 32'(iss_ready_o), 32'd1);
      step();
    end
    #1 chk("t3_full_ready", 32'(iss_ready_o), 32'd0);
    chk("t3_full_stall", 32'(stall_o), 32'd1);
    iss_valid_i = 1'b0;
    #1 chk("t3_novalid_stall", 32'(stall_o), 32'd0);
    chk("t3_novalid_ready", 32'(iss_ready_o), 32'd0);
    iss_valid_i = 1'b1;
    step();
    wb(1, 7, 32'h77);
    #1 chk("t3_wb_ready", 32'(iss_ready_o), 32'd1);
    step();
    wb(0, 0, 0);
    #1 chk("t3_still_full", 32'(iss_ready_o), 32'd0);
    issue(0, 0, 0, 0, 0, 0, 0);
    step();

    // x0 hard-wiring
    issue(1, 0, 0, 0, 0, 1, 0);
    #1 chk("t4_rd0_ready", 32'(iss_ready_o), 32'd1);
    step();
    issue(1, 1, 0, 0, 0, 0, 0);
    wb(1, 0, 32'h55);
    #1 chk("t4_rs0_ready", 32'(iss_ready_o), 32'd1);
    step();
    chk("t4_rs0_op_valid", 32'(op_valid_o), 32'd1);
    chk("t4_rs0_data", rs1_data_o, 32'd0);
    chk("t4_wb_err", 32'(wb_err_o), 32'd0);

    // unmatched write-back
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 9, 32'h1234);
    step();
    chk("t5_err_pulse", 32'(wb_err_o), 32'd1);
    wb(0, 0, 0);
    step();
    chk("t5_err_clear", 32'(wb_err_o), 32'd0);
    issue(1, 1, 9, 1, 3, 0, 0);
    #1 chk("t5_ready", 32'(iss_ready_o), 32'd1);
    step();
    chk("t5_rs1", rs1_data_o, 32'h1234);
    chk("t5_rs2", rs2_data_o, 32'hDEADBEEF);
    issue(1, 0, 9, 1, 9, 1, 9);
    step();
    chk("t5_dis_rs1", rs1_data_o, 32'd0);
    chk("t5_self_rs2", rs2_data_o, 32'h1234);
    issue(1, 1, 9, 0, 0, 0, 0);
    #1 chk("t5_self_reserved", 32'(iss_ready_o), 32'd0);

    // reset mid-stream discards reservations
    issue(1, 0, 0, 0, 0, 1, 4);
    step();
    issue(1, 1, 3, 0, 0, 1, 4);
    step();
    chk("t6_pre_rs1", rs1_data_o, 32'hDEADBEEF);
    issue(1, 1, 4, 0, 0, 0, 0);
    #1 chk("t6_pending", 32'(iss_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_op_valid", 32'(op_valid_o), 32'd0);
    chk("t6_rst_rs1", rs1_data_o, 32'd0);
    chk("t6_rst_wb_err", 32'(wb_err_o), 32'd0);
    chk("t6_rst_ready", 32'(iss_ready_o), 32'd1);
    step();
    rst_i = 1'b1;
    issue(1, 1, 4, 1, 3, 0, 0);
    #1 chk("t6_after_ready", 32'(iss_ready_o), 32'd1);
    step();
    chk("t6_after_op_valid", 32'(op_valid_o), 32'd1);
    chk("t6_after_rs1", rs1_data_o, 32'd0);
    chk("t6_after_rs2", rs2_data_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
